// File: rtl/fifo_sync_fwft.sv
// Synchronous first-word-fall-through FIFO with valid/ready on both sides, level flags,
// reject/overwrite full policy and flush. Define FIFO_SYNC_FWFT_STATS_EN for max_count/drop_count.
module fifo_sync_fwft #(
    parameter int DATA_W    = 8,
    parameter int SIZE      = 32,
    parameter int OVERWRITE = 0,
    parameter int AFULL_TH  = SIZE - 4,
    parameter int AEMPTY_TH = 4
) (
    input  logic                  clk,
    input  logic                  aresetn,
    input  logic                  clear,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [$clog2(SIZE):0] data_count,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow,
    output logic                  underflow
`ifdef FIFO_SYNC_FWFT_STATS_EN
    ,
    output logic [$clog2(SIZE):0] max_count,
    output logic [15:0]           drop_count
`endif
);

    localparam int          AW       = $clog2(SIZE);
    localparam bit          OVW      = (OVERWRITE != 0);
    localparam logic [AW:0] SIZE_C   = SIZE[AW:0];
    localparam logic [AW:0] AFULL_C  = AFULL_TH[AW:0];
    localparam logic [AW:0] AEMPTY_C = AEMPTY_TH[AW:0];

    logic [DATA_W-1:0] mem [SIZE];
    logic [AW-1:0]     head;
    logic [AW-1:0]     tail;
    logic [AW:0]       count;
    logic [AW:0]       count_nxt;
    logic              push;
    logic              pop;
    logic              lose_oldest;
    logic              ovf_evt;
    logic              unf_evt;

    always_comb begin
        full         = (count == SIZE_C);
        empty        = (count == '0);
        almost_full  = (count >= AFULL_C);
        almost_empty = (count <= AEMPTY_C);
        rd_valid     = !empty;
        wr_ready     = OVW ? 1'b1 : !full;
        data_count   = count;
        // rd_data is forced to zero while empty so reset/flush never expose stale memory
        rd_data      = empty ? '0 : mem[tail];
        push         = wr_valid && wr_ready;
        pop          = rd_valid && rd_ready;
        lose_oldest  = push && full && !pop;
        ovf_evt      = wr_valid && full && !(OVW && pop);
        unf_evt      = rd_ready && empty;
    end

    always_comb begin
        count_nxt = count;
        if (push && !pop && !full)
            count_nxt = count + 1'b1;
        else if (pop && !push)
            count_nxt = count - 1'b1;
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clear) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push)
                head <= head + 1'b1;
            if (pop || lose_oldest)
                tail <= tail + 1'b1;
            count     <= count_nxt;
            overflow  <= ovf_evt;
            underflow <= unf_evt;
        end
    end

    // Storage carries no reset; flush leaves contents in place
    always_ff @(posedge clk) begin
        if (push && !clear)
            mem[head] <= wr_data;
    end

`ifdef FIFO_SYNC_FWFT_STATS_EN
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            max_count  <= '0;
            drop_count <= '0;
        end else if (clear) begin
            max_count  <= '0;
            drop_count <= '0;
        end else begin
            if (count_nxt > max_count)
                max_count <= count_nxt;
            if (ovf_evt && (drop_count != 16'hFFFF))
                drop_count <= drop_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_sync_fwft.sv
// Randomized scoreboard bench for fifo_sync_fwft: a reject-policy and an overwrite-policy
// instance share stimulus and are each checked against a list-based reference model.
module tb_fifo_sync_fwft;

    localparam int SIZE = 32;
    localparam int DW   = 8;
    localparam int CW   = $clog2(SIZE) + 1;

    logic          clk;
    logic          aresetn;
    logic          clear;
    logic [DW-1:0] wr_data;
    logic          wr_valid;
    logic          rd_ready;

    logic [1:0]    wr_ready_v;
    logic [1:0]    rd_valid_v;
    logic [1:0]    full_v;
    logic [1:0]    empty_v;
    logic [1:0]    afull_v;
    logic [1:0]    aempty_v;
    logic [1:0]    ovf_v;
    logic [1:0]    unf_v;
    logic [DW-1:0] rd_data_v [2];
    logic [CW-1:0] count_v   [2];
`ifdef FIFO_SYNC_FWFT_STATS_EN
    logic [CW-1:0] max_v     [2];
    logic [15:0]   drop_v    [2];
`endif

    // reference model: ordered content list per instance, oldest word at index 0
    logic [DW-1:0] mc [2][SIZE];
    int            mn    [2];
    bit            e_ovf [2];
    bit            e_unf [2];
    int            mmax  [2];
    int            mdrop [2];
    logic [DW-1:0] exp0 [$];
    logic [DW-1:0] exp1 [$];

    int checks;
    int errors;

    fifo_sync_fwft #(.DATA_W(DW), .SIZE(SIZE), .OVERWRITE(0)) u_rej (
`ifdef FIFO_SYNC_FWFT_STATS_EN
        .max_count(max_v[0]), .drop_count(drop_v[0]),
`endif
        .clk(clk), .aresetn(aresetn), .clear(clear),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready_v[0]),
        .rd_data(rd_data_v[0]), .rd_valid(rd_valid_v[0]), .rd_ready(rd_ready),
        .data_count(count_v[0]), .full(full_v[0]), .empty(empty_v[0]),
        .almost_full(afull_v[0]), .almost_empty(aempty_v[0]),
        .overflow(ovf_v[0]), .underflow(unf_v[0])
    );

    fifo_sync_fwft #(.DATA_W(DW), .SIZE(SIZE), .OVERWRITE(1)) u_ovw (
`ifdef FIFO_SYNC_FWFT_STATS_EN
        .max_count(max_v[1]), .drop_count(drop_v[1]),
`endif
        .clk(clk), .aresetn(aresetn), .clear(clear),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready_v[1]),
        .rd_data(rd_data_v[1]), .rd_valid(rd_valid_v[1]), .rd_ready(rd_ready),
        .data_count(count_v[1]), .full(full_v[1]), .empty(empty_v[1]),
        .almost_full(afull_v[1]), .almost_empty(aempty_v[1]),
        .overflow(ovf_v[1]), .underflow(unf_v[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic drop_front(input int i);
        for (int k = 0; k < SIZE - 1; k++)
            mc[i][k] = mc[i][k+1];
        mn[i] = mn[i] - 1;
    endtask

    // advance the model by one clock edge, using the state before the edge
    task automatic model_step(input int i, input bit w, input logic [DW-1:0] d,
                              input bit r, input bit c);
        bit was_full, was_empty, pop, acc;
        was_full  = (mn[i] == SIZE);
        was_empty = (mn[i] == 0);
        if (c) begin
            mn[i] = 0; e_ovf[i] = 0; e_unf[i] = 0; mmax[i] = 0; mdrop[i] = 0;
        end else begin
            pop      = r && !was_empty;
            acc      = w && ((i == 1) || !was_full);
            e_unf[i] = r && was_empty;
            e_ovf[i] = w && was_full && !((i == 1) && pop);
            if (pop) begin
                if (i == 0) exp0.push_back(mc[i][0]);
                else        exp1.push_back(mc[i][0]);
                drop_front(i);
            end
            if (acc) begin
                if (mn[i] == SIZE) drop_front(i);
                mc[i][mn[i]] = d;
                mn[i] = mn[i] + 1;
            end
            if (e_ovf[i] && mdrop[i] < 65535) mdrop[i]++;
            if (mn[i] > mmax[i]) mmax[i] = mn[i];
        end
    endtask

    task automatic check_state(input int i);
        string s;
        s = $sformatf("u%0d_", i);
        chk({s, "data_count"},   count_v[i],    mn[i]);
        chk({s, "full"},         full_v[i],     mn[i] == SIZE);
        chk({s, "empty"},        empty_v[i],    mn[i] == 0);
        chk({s, "almost_full"},  afull_v[i],    mn[i] >= SIZE - 4);
        chk({s, "almost_empty"}, aempty_v[i],   mn[i] <= 4);
        chk({s, "rd_valid"},     rd_valid_v[i], mn[i] != 0);
        chk({s, "wr_ready"},     wr_ready_v[i], (i == 1) || (mn[i] != SIZE));
        chk({s, "overflow"},     ovf_v[i],      e_ovf[i]);
        chk({s, "underflow"},    unf_v[i],      e_unf[i]);
        if (mn[i] > 0)
            chk({s, "rd_data_head"}, rd_data_v[i], mc[i][0]);
`ifdef FIFO_SYNC_FWFT_STATS_EN
        chk({s, "max_count"},  max_v[i],  mmax[i]);
        chk({s, "drop_count"}, drop_v[i], mdrop[i]);
`endif
    endtask

    // called at a falling edge: drive, predict, then check after the next rising edge
    task automatic cycle(input bit w, input logic [DW-1:0] d, input bit r, input bit c);
        wr_valid = w; wr_data = d; rd_ready = r; clear = c;
        model_step(0, w, d, r, c);
        model_step(1, w, d, r, c);
        @(negedge clk);
        check_state(0);
        check_state(1);
    endtask

    // scoreboard monitor: every accepted read is compared against the predicted stream
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (aresetn && !clear) begin
                for (int i = 0; i < 2; i++) begin
                    if (rd_valid_v[i] && rd_ready) begin
                        if (i == 0) begin
                            if (exp0.size() == 0) chk("u0_unexpected_read", 1, 0);
                            else chk("u0_rd_data", rd_data_v[0], exp0.pop_front());
                        end else begin
                            if (exp1.size() == 0) chk("u1_unexpected_read", 1, 0);
                            else chk("u1_rd_data", rd_data_v[1], exp1.pop_front());
                        end
                    end
                end
            end
        end
    end

    initial begin
        int pw, pr;
        checks = 0; errors = 0;
        for (int i = 0; i < 2; i++) begin
            mn[i] = 0; e_ovf[i] = 0; e_unf[i] = 0; mmax[i] = 0; mdrop[i] = 0;
        end
        aresetn = 1'b0; clear = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0; wr_data = '0;
        repeat (2) @(negedge clk);
        check_state(0);
        check_state(1);
        chk("u0_rd_data_reset", rd_data_v[0], 0);
        chk("u1_rd_data_reset", rd_data_v[1], 0);
        aresetn = 1'b1;

        for (int v = 1; v <= 8; v++) cycle(1, 8'(v), 0, 0);
        repeat (9) cycle(0, 8'h00, 1, 0);

        for (int v = 0; v <= 32; v++) cycle(1, 8'(v), 0, 0);
        repeat (34) cycle(0, 8'h00, 1, 0);

        repeat (5) cycle(1, 8'($urandom_range(0, 255)), 0, 0);
        repeat (10) cycle(1, 8'($urandom_range(0, 255)), 1, 0);
        repeat (6) cycle(0, 8'h00, 1, 0);

        cycle(1, 8'hA5, 1, 0);
        cycle(0, 8'h00, 1, 0);

        repeat (20) cycle(1, 8'($urandom_range(0, 255)), 0, 0);
        cycle(1, 8'h5A, 1, 1);
        cycle(0, 8'h00, 0, 0);

        pw = 50; pr = 50;
        for (int n = 0; n < 3000; n++) begin
            if (n % 200 == 0) begin
                pw = $urandom_range(10, 95);
                pr = $urandom_range(10, 95);
            end
            cycle($urandom_range(0, 99) < pw, 8'($urandom_range(0, 255)),
                  $urandom_range(0, 99) < pr, $urandom_range(0, 149) == 0);
        end

        repeat (SIZE + 2) cycle(0, 8'h00, 1, 0);
        chk("u0_reads_outstanding", exp0.size(), 0);
        chk("u1_reads_outstanding", exp1.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
